// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard control bundle: stage status in, latch enables/flushes and statistics out.
// master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             ihit;
  logic             dhit;
  logic [4:0]       dc_rs;
  logic [4:0]       dc_rt;
  logic             dc_uses_rt;
  logic             ex_d_ren;
  logic [4:0]       ex_wsel;
  logic             ex_branch_taken;
  logic             ex_halt;
  logic             mem_dreq;
  logic             pc_en;
  logic             ifdc_en;
  logic             dcex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifdc_flush;
  logic             dcex_flush;
  logic             exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, dc_rs, dc_rt, dc_uses_rt, ex_d_ren, ex_wsel,
           ex_branch_taken, ex_halt, mem_dreq,
    input  pc_en, ifdc_en, dcex_en, exmem_en, memwb_en,
           ifdc_flush, dcex_flush, exmem_flush, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dc_rs, dc_rt, dc_uses_rt, ex_d_ren, ex_wsel,
           ex_branch_taken, ex_halt, mem_dreq,
    output pc_en, ifdc_en, dcex_en, exmem_en, memwb_en,
           ifdc_flush, dcex_flush, exmem_flush, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: enables/flushes are combinational (0 cycles), halt and counters registered.
// A pending dcache miss freezes the whole pipe; halt drains EX/MEM/WB then parks until reset.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic         CLK,
  input logic         RST,
  hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             memwait;
  logic             loaduse;
  logic             flush_evt;
  logic             pc_en;
  logic             ifdc_en;
  logic             dcex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifdc_flush;
  logic             dcex_flush;
  logic             exmem_flush;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign memwait = hif.mem_dreq & ~hif.dhit;

  // A load into $0 never produces a value, so it cannot create a dependency.
  assign loaduse = hif.ex_d_ren & (hif.ex_wsel != 5'd0) &
                   ((hif.ex_wsel == hif.dc_rs) |
                    (hif.dc_uses_rt & (hif.ex_wsel == hif.dc_rt)));

  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b0;
    ifdc_en     = 1'b0;
    dcex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifdc_flush  = 1'b0;
    dcex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_evt   = 1'b0;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nxt = RUN;
        end else if (hif.ex_halt) begin
          state_nxt  = DRAIN;
          dcex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          dcex_flush = 1'b1;
        end else if (hif.ex_branch_taken) begin
          pc_en      = 1'b1;
          ifdc_en    = 1'b1;
          dcex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifdc_flush = 1'b1;
          dcex_flush = 1'b1;
          flush_evt  = 1'b1;
        end else if (loaduse) begin
          dcex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          dcex_flush = 1'b1;
        end else if (!hif.ihit) begin
          ifdc_en    = 1'b1;
          dcex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifdc_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifdc_en  = 1'b1;
          dcex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      DRAIN: begin
        exmem_en = ~memwait;
        memwb_en = ~memwait;
        if (!hif.mem_dreq || hif.dhit) state_nxt = HALTED;
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state  <= state_nxt;
      halt_q <= (state_nxt == HALTED);
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hif.pc_en       = pc_en;
  assign hif.ifdc_en     = ifdc_en;
  assign hif.dcex_en     = dcex_en;
  assign hif.exmem_en    = exmem_en;
  assign hif.memwb_en    = memwb_en;
  assign hif.ifdc_flush  = ifdc_flush;
  assign hif.dcex_flush  = dcex_flush;
  assign hif.exmem_flush = exmem_flush;
  assign hif.halt        = halt_q;
  assign hif.stall_cnt   = stall_q;
  assign hif.flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed table, hand sequences for drain/memwait/saturation, randomized run vs reference model.
module tb_hazard_ctrl;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .hif(hif.slave));

  typedef struct {
    logic       ihit;
    logic       dhit;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       dren;
    logic [4:0] wsel;
    logic       br;
    logic       hlt;
    logic       mreq;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
    logic [7:0] care;
    int         stall;
    int         flush;
    string      name;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: where the CPU is in its halt sequence, plus event tallies.
  bit draining, halted, m_halt;
  int m_stall, m_flush;

  function automatic in_t mk_in(bit ihit, bit dhit, int rs, int rt, bit urt,
                                bit dren, int wsel, bit br, bit hlt, bit mreq);
    in_t r;
    r.ihit = ihit; r.dhit = dhit; r.rs = 5'(rs); r.rt = 5'(rt); r.urt = urt;
    r.dren = dren; r.wsel = 5'(wsel); r.br = br; r.hlt = hlt; r.mreq = mreq;
    return r;
  endfunction

  function automatic logic [7:0] outs();
    return {hif.pc_en, hif.ifdc_en, hif.dcex_en, hif.exmem_en, hif.memwb_en,
            hif.ifdc_flush, hif.dcex_flush, hif.exmem_flush};
  endfunction

  task automatic drive(input in_t i, input bit rst);
    @(negedge CLK);
    RST = rst;
    hif.ihit = i.ihit; hif.dhit = i.dhit; hif.dc_rs = i.rs; hif.dc_rt = i.rt;
    hif.dc_uses_rt = i.urt; hif.ex_d_ren = i.dren; hif.ex_wsel = i.wsel;
    hif.ex_branch_taken = i.br; hif.ex_halt = i.hlt; hif.mem_dreq = i.mreq;
    #2;
  endtask

  task automatic chk_outs(input string nm, input logic [7:0] exp, input logic [7:0] care);
    logic [7:0] act;
    act = outs();
    n_tests++;
    if (((act ^ exp) & care) != 8'd0) begin
      n_fail++;
      $display("FAIL %s: outs got %b want %b (care %b) t=%0t", nm, act, exp, care, $time);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected behaviour for the current cycle, straight from the priority rules.
  task automatic model_eval(input in_t i, output logic [7:0] e, output logic [7:0] care,
                            output bit stall, output bit fl, output bit go_drain, output bit go_halt);
    bit pc, ifd, dce, exm, mwb, fi, fd, busy, dep;
    pc = 0; ifd = 0; dce = 0; exm = 0; mwb = 0; fi = 0; fd = 0;
    care = 8'hFF; fl = 0; go_drain = 0; go_halt = 0;
    busy = i.mreq && !i.dhit;
    dep  = i.dren && (i.wsel != 0) &&
           ((i.wsel == i.rs) || (i.urt && (i.wsel == i.rt)));
    if (halted) begin
    end else if (draining) begin
      exm = !busy; mwb = !busy;
      go_halt = !i.mreq || i.dhit;
    end else if (busy) begin
    end else if (i.hlt) begin
      exm = 1; mwb = 1; fd = 1; care[5] = 0; go_drain = 1;
    end else if (i.br) begin
      {pc, ifd, dce, exm, mwb, fi, fd} = 7'h7F; fl = 1;
    end else if (dep) begin
      exm = 1; mwb = 1; fd = 1; care[5] = 0;
    end else if (!i.ihit) begin
      dce = 1; exm = 1; mwb = 1; fi = 1; care[6] = 0;
    end else begin
      {pc, ifd, dce, exm, mwb} = 5'h1F;
    end
    e = {pc, ifd, dce, exm, mwb, fi, fd, 1'b0};
    stall = !pc;
  endtask

  task automatic model_reset();
    draining = 0; halted = 0; m_halt = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step(input in_t i, input bit rst);
    logic [7:0] e, c;
    bit st, fl, gd, gh;
    model_eval(i, e, c, st, fl, gd, gh);
    if (rst) begin
      model_reset();
    end else begin
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
      if (gd) draining = 1;
      if (gh) begin draining = 0; halted = 1; end
      m_halt = halted;
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk_vec(in_t in, logic [7:0] exp, logic [7:0] care,
                                  int st, int fl, string nm);
    vec_t v;
    v.in = in; v.exp = exp; v.care = care; v.stall = st; v.flush = fl; v.name = nm;
    return v;
  endfunction

  initial begin
    in_t idle, r;
    logic [7:0] e, c;
    bit st, fl, gd, gh;

    idle = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //                      ihit dhit rs rt urt dren wsel br hlt mreq
    vecs.push_back(mk_vec(mk_in(1, 0, 5, 0, 0, 1, 5, 0, 0, 0), 8'b00111010, 8'hDF, 1, 0, "loaduse_rs"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0), 8'b11111000, 8'hFF, 0, 0, "load_r0"));
    vecs.push_back(mk_vec(mk_in(1, 0, 5, 0, 0, 1, 5, 1, 0, 0), 8'b11111110, 8'hFF, 0, 1, "branch_vs_loaduse"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), 8'b00000000, 8'hFF, 1, 0, "memwait"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), 8'b00000000, 8'hFF, 1, 0, "memwait_vs_halt"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 1), 8'b00000000, 8'hFF, 1, 0, "memwait_vs_branch"));
    vecs.push_back(mk_vec(mk_in(1, 0, 3, 7, 1, 1, 7, 0, 0, 0), 8'b00111010, 8'hDF, 1, 0, "loaduse_rt"));
    vecs.push_back(mk_vec(mk_in(1, 0, 3, 7, 0, 1, 7, 0, 0, 0), 8'b11111000, 8'hFF, 0, 0, "rt_not_read"));
    vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b01111100, 8'hBF, 1, 0, "imiss"));
    vecs.push_back(mk_vec(mk_in(0, 0, 5, 0, 0, 1, 5, 0, 0, 0), 8'b00111010, 8'hDF, 1, 0, "loaduse_vs_imiss"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 8'b00111010, 8'hDF, 1, 0, "halt"));
    vecs.push_back(mk_vec(mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1), 8'b11111000, 8'hFF, 0, 0, "dreq_hit"));
    vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 8'b11111110, 8'hFF, 0, 1, "branch_vs_imiss"));
    vecs.push_back(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), 8'b00111010, 8'hDF, 1, 0, "halt_vs_branch"));
    vecs.push_back(mk_vec(mk_in(1, 0, 5, 0, 1, 1, 4, 0, 0, 0), 8'b11111000, 8'hFF, 0, 0, "wsel_mismatch"));

    // Reset state
    drive(idle, 1);
    drive(idle, 0);
    chk_outs("reset_outs", 8'b11111000, 8'hFF);
    chk_val("reset_halt", int'(hif.halt), 0);
    chk_val("reset_stall", int'(hif.stall_cnt), 0);
    chk_val("reset_flush", int'(hif.flush_cnt), 0);

    foreach (vecs[k]) begin
      drive(idle, 1);
      drive(vecs[k].in, 0);
      chk_outs(vecs[k].name, vecs[k].exp, vecs[k].care);
      drive(idle, 0);
      chk_val({vecs[k].name, "_stall"}, int'(hif.stall_cnt), vecs[k].stall);
      chk_val({vecs[k].name, "_flush"}, int'(hif.flush_cnt), vecs[k].flush);
    end

    // Memwait: three frozen cycles, released on the hit
    drive(idle, 1);
    r = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(r, 0);
      chk_outs($sformatf("memwait_seq_%0d", k), 8'b00000000, 8'hFF);
    end
    r.dhit = 1;
    drive(r, 0);
    chk_outs("memwait_release", 8'b11111000, 8'hFF);
    drive(idle, 0);
    chk_val("memwait_stall", int'(hif.stall_cnt), 3);

    // Halt drain with an outstanding miss, then reset out of HALTED
    drive(idle, 1);
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0);
    chk_outs("halt_enter", 8'b00111010, 8'hDF);
    r = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      drive(r, 0);
      chk_outs($sformatf("drain_wait_%0d", k), 8'b00000000, 8'hFF);
      chk_val($sformatf("drain_halt_%0d", k), int'(hif.halt), 0);
    end
    r.dhit = 1;
    drive(r, 0);
    chk_outs("drain_hit", 8'b00011000, 8'hFF);
    chk_val("drain_hit_halt", int'(hif.halt), 0);
    for (int k = 0; k < 3; k++) begin
      drive(mk_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);
      chk_val($sformatf("halted_halt_%0d", k), int'(hif.halt), 1);
      chk_outs($sformatf("halted_outs_%0d", k), 8'b00000000, 8'hFF);
    end
    chk_val("halted_stall", int'(hif.stall_cnt), 6);
    chk_val("halted_flush", int'(hif.flush_cnt), 0);
    drive(idle, 1);
    drive(idle, 0);
    chk_val("halt_rst_halt", int'(hif.halt), 0);
    chk_outs("halt_rst_outs", 8'b11111000, 8'hFF);

    // Counter saturation and reset clearing both counters
    drive(idle, 1);
    for (int k = 0; k < (1 << CW) + 3; k++) drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    for (int k = 0; k < (1 << CW) + 3; k++) drive(mk_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    drive(idle, 0);
    chk_val("stall_sat", int'(hif.stall_cnt), CMAX);
    chk_val("flush_sat", int'(hif.flush_cnt), CMAX);
    drive(idle, 1);
    drive(idle, 0);
    chk_val("sat_rst_stall", int'(hif.stall_cnt), 0);
    chk_val("sat_rst_flush", int'(hif.flush_cnt), 0);
    chk_val("sat_rst_halt", int'(hif.halt), 0);

    // Randomized run against the reference model
    drive(idle, 1);
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      bit rst;
      r.ihit = ($urandom_range(0, 7) != 0);
      r.dhit = 1'($urandom_range(0, 1));
      r.rs   = 5'($urandom_range(0, 3));
      r.rt   = 5'($urandom_range(0, 3));
      r.urt  = 1'($urandom_range(0, 1));
      r.dren = ($urandom_range(0, 9) < 3);
      r.wsel = 5'($urandom_range(0, 3));
      r.br   = ($urandom_range(0, 7) == 0);
      r.hlt  = ($urandom_range(0, 31) == 0);
      r.mreq = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      drive(r, rst);
      model_eval(r, e, c, st, fl, gd, gh);
      chk_outs($sformatf("rand_outs_%0d", k), e, c);
      chk_val($sformatf("rand_halt_%0d", k), int'(hif.halt), int'(m_halt));
      chk_val($sformatf("rand_stall_%0d", k), int'(hif.stall_cnt), m_stall);
      chk_val($sformatf("rand_flush_%0d", k), int'(hif.flush_cnt), m_flush);
      model_step(r, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
